// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: size encodings, FSM states
// and the request fault check used at acceptance time.
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   // Addresses below base wrap to a huge offset, so one compare covers both ends.
   function automatic logic req_fault(input logic [1:0]  size,
                                      input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [32:0] span);
      logic [31:0] off;
      logic        misalign;
      off = addr - base;
      case (size)
         SZ_BYTE: misalign = 1'b0;
         SZ_HALF: misalign = addr[0];
         SZ_WORD: misalign = |addr[1:0];
         default: misalign = 1'b1;
      endcase
      return misalign || ({1'b0, off} >= span);
   endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering: write enables and replicated store data for the RAM word,
// and right-justified, zero-extended load data from the addressed word.
module dmem_lane
   import dmem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata
);

   always_comb begin
      be        = 4'b0000;
      wdata_rep = 32'h0;
      rdata     = 32'h0;
      case (size)
         SZ_BYTE: begin
            be        = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
            rdata     = {24'h0, rword[8*addr_lo +: 8]};
         end
         SZ_HALF: begin
            be        = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{wdata[15:0]}};
            rdata     = {16'h0, (addr_lo[1] ? rword[31:16] : rword[15:0])};
         end
         SZ_WORD: begin
            be        = 4'b1111;
            wdata_rep = wdata;
            rdata     = rword;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target for the core's MREQ/ACKD_n bus: one request at a time,
// programmable wait states, one-cycle acknowledge, word-organised RAM.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MREQ,
   input  logic        WRITE,
   input  logic [1:0]  SIZE,
   input  logic [31:0] DAD,
   inout  wire  [31:0] DDT,
   output logic        ACKD_n,
   output logic        err,
   output logic [1:0]  dbg_state
);

   localparam int          AW   = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [1:0]  size_q, size_d;
   logic        write_q, write_d;
   logic        fault_q, fault_d;

   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] off_w;
   logic [AW-1:0] word_idx;
   logic [31:0] rword, wdata_rep, rdata, load_data;
   logic [3:0]  be;
   logic        commit, ddt_oe;

   // Request fields are captured only on acceptance, so the bus may change freely afterwards.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      size_d  = size_q;
      write_d = write_q;
      fault_d = fault_q;
      case (state_q)
         ST_IDLE: begin
            if (MREQ) begin
               addr_d  = DAD;
               wdata_d = DDT;
               size_d  = SIZE;
               write_d = WRITE;
               fault_d = req_fault(SIZE, DAD, BASE_ADDR, SPAN);
               if (WAIT_CYCLES > 0) begin
                  state_d = ST_WAIT;
                  cnt_d   = 4'(WAIT_CYCLES - 1);
               end else begin
                  state_d = ST_ACK;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) state_d = ST_ACK;
            else               cnt_d   = cnt_q - 4'd1;
         end
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         size_q  <= SZ_BYTE;
         write_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         size_q  <= size_d;
         write_q <= write_d;
         fault_q <= fault_d;
      end
   end

   assign off_w    = addr_q - BASE_ADDR;
   assign word_idx = AW'(off_w >> 2);
   assign rword    = mem_q[word_idx];

   dmem_lane u_lane (
      .size      (size_q),
      .addr_lo   (addr_q[1:0]),
      .wdata     (wdata_q),
      .rword     (rword),
      .be        (be),
      .wdata_rep (wdata_rep),
      .rdata     (rdata)
   );

   // Stores land on the edge that closes the ACK cycle; reset on that edge wins.
   assign commit = (state_q == ST_ACK) && write_q && !fault_q;

   always_ff @(posedge clk) begin
      if (!rst && commit) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem_q[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
         end
      end
   end

   assign ddt_oe    = (state_q == ST_ACK) && !write_q;
   assign load_data = fault_q ? 32'h0 : rdata;
   assign DDT       = ddt_oe ? load_data : 32'hzzzz_zzzz;

   assign ACKD_n    = (state_q != ST_ACK);
   assign err       = (state_q == ST_ACK) && fault_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (3 wait states at base 0, no wait
// states at a non-zero base) checked against a byte-addressed memory model.
module tb_dmem_responder;
   import dmem_pkg::*;

   localparam int          W_A    = 3;
   localparam int          W_B    = 0;
   localparam logic [31:0] BASE_A = 32'h0000_0000;
   localparam logic [31:0] BASE_B = 32'h0001_0000;
   localparam int          SPAN   = 4096;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mreq_a = 1'b0, mreq_b = 1'b0, write = 1'b0;
   logic [1:0]  size = 2'b00;
   logic [31:0] dad = 32'h0, ddt_drv = 32'h0;
   logic        ddt_en = 1'b1;
   wire  [31:0] ddt_a, ddt_b;
   logic        ackd_a, ackd_b, err_a, err_b;
   logic [1:0]  dbg_a, dbg_b;

   int n_tests = 0;
   int n_fail  = 0;

   // Bench parks the bus at zero whenever the responder should have released it.
   assign ddt_a = ddt_en ? ddt_drv : 32'hzzzz_zzzz;
   assign ddt_b = ddt_en ? ddt_drv : 32'hzzzz_zzzz;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(BASE_A), .WAIT_CYCLES(W_A)) dut_a (
      .clk(clk), .rst(rst), .MREQ(mreq_a), .WRITE(write), .SIZE(size), .DAD(dad),
      .DDT(ddt_a), .ACKD_n(ackd_a), .err(err_a), .dbg_state(dbg_a)
   );

   dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(BASE_B), .WAIT_CYCLES(W_B)) dut_b (
      .clk(clk), .rst(rst), .MREQ(mreq_b), .WRITE(write), .SIZE(size), .DAD(dad),
      .DDT(ddt_b), .ACKD_n(ackd_b), .err(err_b), .dbg_state(dbg_b)
   );

   // Byte-addressed model of the first 64 bytes of each RAM.
   logic [7:0] mdl [2][64];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int wcyc(input int sel);
      return (sel == 0) ? W_A : W_B;
   endfunction

   function automatic logic [31:0] base_of(input int sel);
      return (sel == 0) ? BASE_A : BASE_B;
   endfunction

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == SZ_BYTE) ? 1 : (sz == SZ_HALF) ? 2 : 4;
   endfunction

   function automatic bit mdl_fault(input int sel, input logic [1:0] sz, input logic [31:0] addr);
      longint off;
      off = longint'(addr) - longint'(base_of(sel));
      if (sz == 2'b11) return 1'b1;
      if ((addr % nbytes(sz)) != 0) return 1'b1;
      return (off < 0) || (off >= SPAN);
   endfunction

   function automatic logic [31:0] mdl_load(input int sel, input logic [1:0] sz, input logic [31:0] addr);
      logic [31:0] r;
      int off;
      r   = 32'h0;
      off = int'(addr - base_of(sel));
      for (int i = 0; i < nbytes(sz); i++) r[8*i +: 8] = mdl[sel][off + i];
      return r;
   endfunction

   function automatic void mdl_store(input int sel, input logic [1:0] sz, input logic [31:0] addr,
                                     input logic [31:0] data);
      int off;
      off = int'(addr - base_of(sel));
      for (int i = 0; i < nbytes(sz); i++) mdl[sel][off + i] = data[8*i +: 8];
   endfunction

   function automatic logic sel_ack(input int sel);
      return (sel == 0) ? ackd_a : ackd_b;
   endfunction

   function automatic logic [31:0] sel_ddt(input int sel);
      return (sel == 0) ? ddt_a : ddt_b;
   endfunction

   task automatic do_req(input int sel, input logic wr, input logic [1:0] sz,
                         input logic [31:0] addr, input logic [31:0] data, output logic [31:0] rd);
      int w;
      bit flt;
      logic [31:0] exp_rd, pat, ddt_ack, ddt_after;
      logic err_ack;
      w      = wcyc(sel);
      flt    = mdl_fault(sel, sz, addr);
      exp_rd = (wr || flt) ? 32'h0 : mdl_load(sel, sz, addr);
      @(negedge clk);
      write = wr; size = sz; dad = addr; ddt_en = 1'b1; ddt_drv = wr ? data : 32'h0;
      if (sel == 0) mreq_a = 1'b1; else mreq_b = 1'b1;
      @(posedge clk); #1;
      mreq_a = 1'b0; mreq_b = 1'b0;
      write = 1'($urandom); size = 2'($urandom); dad = $urandom;
      ddt_drv = 32'h0; ddt_en = wr;
      pat = 32'h0; ddt_ack = 32'h0; ddt_after = 32'h0; err_ack = 1'b0;
      for (int k = 1; k <= w + 2; k++) begin
         @(negedge clk);
         pat[k-1] = ~sel_ack(sel);
         if (k == w + 2) ddt_after = sel_ddt(sel);
         if (k == w + 1) begin
            err_ack = (sel == 0) ? err_a : err_b;
            ddt_ack = sel_ddt(sel);
            @(posedge clk); #1;
            ddt_en = 1'b1; ddt_drv = 32'h0;
         end
      end
      chk("ack_timing", pat, 32'(1) << w);
      chk("err_flag", 32'(err_ack), 32'(flt));
      if (wr) chk("store_ddt_released", ddt_ack, 32'h0);
      else    chk("load_data", ddt_ack, exp_rd);
      chk("idle_ddt_released", ddt_after, 32'h0);
      if (wr && !flt) mdl_store(sel, sz, addr, data);
      rd = ddt_ack;
   endtask

   // MREQ held high: a store immediately followed by a load of the same word.
   task automatic b2b(input int sel, input logic [31:0] addr, input logic [31:0] data);
      int w;
      logic [31:0] pat, ddt2;
      logic err1;
      w = wcyc(sel);
      @(negedge clk);
      write = 1'b1; size = SZ_WORD; dad = addr; ddt_drv = data; ddt_en = 1'b1;
      if (sel == 0) mreq_a = 1'b1; else mreq_b = 1'b1;
      @(posedge clk); #1;
      write = 1'b0; ddt_drv = 32'h0;
      pat = 32'h0; ddt2 = 32'h0; err1 = 1'b1;
      for (int k = 1; k <= 2 * w + 3; k++) begin
         @(negedge clk);
         pat[k-1] = ~sel_ack(sel);
         if (k == w + 1) err1 = (sel == 0) ? err_a : err_b;
         if (k == 2 * w + 3) ddt2 = sel_ddt(sel);
         if (k == w + 2) begin
            @(posedge clk); #1;
            mreq_a = 1'b0; mreq_b = 1'b0; ddt_en = 1'b0;
         end
      end
      ddt_en = 1'b1; ddt_drv = 32'h0;
      chk("b2b_ack_pattern", pat, (32'(1) << w) | (32'(1) << (2 * w + 2)));
      chk("b2b_store_err", 32'(err1), 32'h0);
      chk("b2b_load_data", ddt2, data);
      mdl_store(sel, SZ_WORD, addr, data);
   endtask

   // Reset asserted k_rst cycles after accepting a store; the store must vanish.
   task automatic rst_test(input int sel, input logic [31:0] addr, input int k_rst);
      logic [31:0] rd;
      int lows;
      @(negedge clk);
      write = 1'b1; size = SZ_WORD; dad = addr; ddt_drv = $urandom; ddt_en = 1'b1;
      if (sel == 0) mreq_a = 1'b1; else mreq_b = 1'b1;
      @(posedge clk); #1;
      mreq_a = 1'b0; mreq_b = 1'b0; ddt_drv = 32'h0;
      for (int k = 1; k <= k_rst; k++) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_ackd_high", 32'(sel_ack(sel)), 32'h1);
      chk("rst_ddt_released", sel_ddt(sel), 32'h0);
      chk("rst_state_idle", 32'((sel == 0) ? dbg_a : dbg_b), 32'(ST_IDLE));
      rst = 1'b0;
      lows = 0;
      repeat (4) begin
         @(negedge clk);
         if (!sel_ack(sel)) lows++;
      end
      chk("rst_no_ack", 32'(lows), 32'h0);
      do_req(sel, 1'b0, SZ_WORD, addr, 32'h0, rd);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int sel, r, off;
      logic wr;
      logic [1:0] sz;
      logic [31:0] addr, rd;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_ackd_a", 32'(ackd_a), 32'h1);
      chk("reset_ackd_b", 32'(ackd_b), 32'h1);
      chk("reset_err_a", 32'(err_a), 32'h0);
      chk("reset_err_b", 32'(err_b), 32'h0);
      chk("reset_ddt_a", ddt_a, 32'h0);
      chk("reset_state_a", 32'(dbg_a), 32'(ST_IDLE));
      rst = 1'b0;

      for (int s = 0; s < 2; s++)
         for (int i = 0; i < 16; i++)
            do_req(s, 1'b1, SZ_WORD, base_of(s) + 32'(4 * i), $urandom, rd);

      do_req(0, 1'b1, SZ_WORD, 32'h10, 32'hDEAD_BEEF, rd);
      do_req(0, 1'b0, SZ_WORD, 32'h10, 32'h0, rd);
      chk("tp_word_load", rd, 32'hDEAD_BEEF);
      do_req(0, 1'b1, SZ_WORD, 32'h10, 32'h1122_3344, rd);
      do_req(0, 1'b1, SZ_BYTE, 32'h13, 32'hFFFF_FFA5, rd);
      do_req(0, 1'b0, SZ_WORD, 32'h10, 32'h0, rd);
      chk("tp_byte_merge", rd, 32'hA522_3344);
      do_req(0, 1'b0, SZ_BYTE, 32'h13, 32'h0, rd);
      chk("tp_byte_load", rd, 32'h0000_00A5);
      do_req(0, 1'b1, SZ_WORD, 32'h10, 32'h8765_4321, rd);
      do_req(0, 1'b0, SZ_HALF, 32'h12, 32'h0, rd);
      chk("tp_half_load", rd, 32'h0000_8765);
      do_req(0, 1'b0, SZ_HALF, 32'h11, 32'h0, rd);
      chk("tp_half_misaligned_load", rd, 32'h0);
      do_req(0, 1'b1, SZ_HALF, 32'h11, 32'h0000_FFFF, rd);
      do_req(0, 1'b1, SZ_RSVD, 32'h10, 32'h0000_0000, rd);
      do_req(0, 1'b0, SZ_WORD, 32'h10, 32'h0, rd);
      chk("tp_faulted_stores_no_change", rd, 32'h8765_4321);
      do_req(0, 1'b1, SZ_WORD, BASE_A + 32'(SPAN), 32'hCAFE_F00D, rd);
      do_req(0, 1'b0, SZ_WORD, BASE_A, 32'h0, rd);
      do_req(1, 1'b1, SZ_WORD, BASE_B + 32'(SPAN), 32'hCAFE_F00D, rd);
      do_req(1, 1'b1, SZ_WORD, BASE_B - 32'd4, 32'h1234_5678, rd);
      do_req(1, 1'b0, SZ_WORD, BASE_B, 32'h0, rd);
      do_req(1, 1'b1, SZ_HALF, BASE_B + 32'h6, 32'h0000_BEEF, rd);
      do_req(1, 1'b0, SZ_HALF, BASE_B + 32'h6, 32'h0, rd);
      chk("tp_half_roundtrip_b", rd, 32'h0000_BEEF);

      b2b(0, 32'h20, 32'h0BAD_CAFE);
      b2b(1, BASE_B + 32'h24, 32'h5A5A_1234);
      rst_test(0, 32'h14, 1);
      rst_test(1, BASE_B + 32'h28, 1);

      repeat (300) begin
         sel = $urandom_range(0, 1);
         wr  = 1'($urandom_range(0, 1));
         r   = $urandom_range(0, 19);
         off = $urandom_range(0, 63);
         sz  = (r == 0) ? SZ_RSVD : 2'($urandom_range(0, 2));
         if (r == 1)               addr = base_of(sel) + 32'(SPAN + off);
         else if (r == 2 && sel == 1) addr = base_of(sel) - 32'(4 + off);
         else                      addr = base_of(sel) + 32'(off);
         do_req(sel, wr, sz, addr, $urandom, rd);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined core's data bus: the target end of the MREQ/WRITE/SIZE/DAD/DDT/ACKD_n handshake the core initiates from its M stage. Holds a word-organised RAM, accepts one request at a time, inserts a programmable number of wait states, then acknowledges with a one-cycle active-low ACKD_n pulse. Used as the data memory in core-level benches and as the on-chip data RAM in small builds.

## Interface
- DEPTH_WORDS, 1024: RAM size in 32-bit words; power of two.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be aligned to the RAM size.
- WAIT_CYCLES, 1: wait states between acceptance and ACK; 0..15.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- MREQ  in  1  request valid, level.
- WRITE  in  1  1 = store, 0 = load; valid with MREQ.
- SIZE  in  2  00 byte, 01 half, 10 word, 11 reserved.
- DAD  in  32  byte address.
- DDT  inout  32  store data in, low-aligned; load data out.
- ACKD_n  out  1  active-low acknowledge, one cycle per request.
- err  out  1  high with ACKD_n low when the request faulted.

## Operation
- FSM states: IDLE, WAIT, ACK.
- IDLE: if MREQ=1, latch DAD, WRITE, SIZE and DDT (store data); go to WAIT when WAIT_CYCLES>0, else ACK.
- WAIT: counter loads WAIT_CYCLES-1 on acceptance, decrements each cycle; at 0 go to ACK.
- ACK: ACKD_n=0 for exactly this cycle; next state IDLE unconditionally.
- Inputs are ignored outside IDLE; changes to DAD/SIZE/DDT after acceptance have no effect.
- Fault: address not aligned to size (half: DAD[0]=1; word: DAD[1:0]≠0), SIZE=11, or address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS). Faulted request still acknowledged (never hangs); err=1 in ACK cycle; store suppressed; load returns 0.
- Little-endian lanes. Store: byte writes DDT[7:0] to lane DAD[1:0]; half writes DDT[15:0] to lanes {DAD[1],0}+1..+0; word writes all lanes. Other lanes unchanged.
- Load: selected byte/half right-justified into DDT[7:0]/[15:0], upper bits zero; sign extension is the core's job. Word returns full word.
- DDT driven only in ACK cycle of a non-faulted or faulted load; high-Z otherwise (always high-Z for stores).
- RAM contents are not reset.

## Timing
- Request accepted at edge E (state IDLE, MREQ=1); ACKD_n low during cycle E+1+WAIT_CYCLES (WAIT_CYCLES=0: cycle immediately after acceptance).
- Store commits to RAM at the edge ending the ACK cycle; load data is RAM content at ACK time.
- MREQ still high in the cycle after ACK is a new request, accepted immediately (back-to-back, one idle-less turnaround; throughput one request per WAIT_CYCLES+2 cycles).
- Reset values: state IDLE, ACKD_n=1, err=0, DDT high-Z, counter 0.
- rst mid-request (WAIT or ACK): return to IDLE next edge, no ACK, pending store dropped; rst has priority over a simultaneous commit.

## Structure
- Package dmem_pkg: SIZE encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state enum, fault-check function.
- Sub-module dmem_lane: combinational byte-enable generation, store data lane replication, load data extraction/right-justification; FSM, counter, RAM and tri-state in dmem_responder.

## Test plan
- Word store 32'hDEADBEEF at 0x10, word load 0x10 -> DDT=32'hDEADBEEF, err=0, ACKD_n low exactly one cycle.
- Byte store 8'hA5 at 0x13 over word 0x11223344 at 0x10, word load -> 32'hA5223344; byte load 0x13 -> 32'h000000A5.
- Half load at 0x12 of 32'h8765_4321 -> 32'h00008765; half load at 0x11 -> err=1, DDT=0; half store at 0x11 leaves RAM unchanged.
- WAIT_CYCLES=3: MREQ accepted at edge E -> ACKD_n low in cycle E+4 only; WAIT_CYCLES=0 -> cycle E+1.
- Out-of-range store at BASE_ADDR+4*DEPTH_WORDS and SIZE=11 -> ACK with err=1, no RAM change.
- rst asserted during WAIT of a store -> no ACK, ACKD_n=1, DDT high-Z, later load shows old value; MREQ held high across two requests -> two ACKs, both serviced.
